// File: rtl/alu_op_pkg.sv
// alu_op_pkg: shared definitions for the alu_op_ctrl sequencer.
//   - ALU select encodings understood by the femtoRV32 combinational ALU
//   - RV32I major opcodes handled by the sequencer
//   - internal operation and FSM state enums
// Build option: ALU_OP_CTRL_SHIFT_EN adds the SHIFT state.
package alu_op_pkg;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSlt, OpSltu, OpSll, OpSrl, OpSra, OpIll
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StExec2,
`ifdef ALU_OP_CTRL_SHIFT_EN
        StShift,
`endif
        StDone
    } state_e;

    // ALU select for the first (or only) pass of an operation.
    function automatic logic [3:0] first_sel(op_e op);
        logic [3:0] sel;
        case (op)
            OpSub, OpSlt, OpSltu: sel = SEL_SUB;
            OpAnd:                sel = SEL_AND;
            OpOr, OpXor:          sel = SEL_OR;
            default:              sel = SEL_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_op_ctrl_serial_shifter.sv
// serial_shifter: one-bit-per-cycle barrel-free shifter.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   load_i            capture data_i/shamt_i/dir_i/arith_i and start
//   data_i, shamt_i   value to shift and shift amount
//   dir_i             0 = left, 1 = right
//   arith_i           right shifts replicate the sign bit
//   data_o            current (final once done_o) shifted value
//   busy_o            shift in progress
//   done_o            high in the cycle the remaining count reaches zero
module serial_shifter #(
    parameter int unsigned Width = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_i,
    input  logic [Width-1:0]         data_i,
    input  logic [$clog2(Width)-1:0] shamt_i,
    input  logic                     dir_i,
    input  logic                     arith_i,
    output logic [Width-1:0]         data_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int unsigned ShW = $clog2(Width);

    logic [Width-1:0] data_q, data_d;
    logic [ShW-1:0]   count_q, count_d;
    logic             busy_q, busy_d;
    logic             dir_q, dir_d;
    logic             arith_q, arith_d;

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        busy_d  = busy_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        if (load_i) begin
            data_d  = data_i;
            count_d = shamt_i;
            busy_d  = 1'b1;
            dir_d   = dir_i;
            arith_d = arith_i;
        end else if (busy_q) begin
            if (count_q == '0) begin
                busy_d = 1'b0;
            end else begin
                count_d = count_q - {{(ShW-1){1'b0}}, 1'b1};
                data_d  = dir_q ? {arith_q & data_q[Width-1], data_q[Width-1:1]}
                                : {data_q[Width-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

    assign data_o = data_q;
    assign busy_o = busy_q;
    assign done_o = busy_q && (count_q == '0);

endmodule

// File: rtl/alu_op_ctrl.sv
// alu_op_ctrl: sequencing front end for the femtoRV32 combinational ALU.
// Accepts one decoded instruction on start_i & ready_o, drives the ALU from
// registered operands (two passes for XOR), adds SLT/SLTU/XOR and serial
// shifts, and returns a registered result with a one-cycle out_valid_o pulse.
// Build option: define ALU_OP_CTRL_SHIFT_EN to implement SLL/SRL/SRA; without
// it funct3 001/101 decode as illegal.
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   start_i / ready_o               request handshake (ready only in IDLE)
//   opcode_i, funct3_i, funct7_5_i  instruction fields
//   rs1_val_i, rs2_val_i, imm_i     operands, sampled on accept
//   alu_a_o, alu_b_o, alu_sel_o     to the ALU
//   alu_result_i, alu_zero_i        from the ALU
//   result_o, zero_o, illegal_o     registered outcome
//   out_valid_o                     one-cycle completion pulse
module alu_op_ctrl
    import alu_op_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    output logic         ready_o,
    input  logic [6:0]   opcode_i,
    input  logic [2:0]   funct3_i,
    input  logic         funct7_5_i,
    input  logic [N-1:0] rs1_val_i,
    input  logic [N-1:0] rs2_val_i,
    input  logic [N-1:0] imm_i,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic [3:0]   alu_sel_o,
    input  logic [N-1:0] alu_result_i,
    input  logic         alu_zero_i,
    output logic [N-1:0] result_o,
    output logic         zero_o,
    output logic         illegal_o,
    output logic         out_valid_o
);

    state_e       state_q, state_d;
    op_e          op_q, op_d;
    logic [N-1:0] alu_a_q, alu_a_d;
    logic [N-1:0] alu_b_q, alu_b_d;
    logic [3:0]   alu_sel_q, alu_sel_d;
    logic [N-1:0] tmp_q, tmp_d;
    logic [N-1:0] result_q, result_d;
    logic         zero_q, zero_d;
    logic         illegal_q, illegal_d;

    op_e          dec_op;
    logic [N-1:0] dec_b;
    logic         accept;

    function automatic op_e decode_f3(logic [2:0] f3, logic f75, logic is_reg);
        op_e op;
        case (f3)
            3'b000:  op = (is_reg && f75) ? OpSub : OpAdd;
            3'b111:  op = OpAnd;
            3'b110:  op = OpOr;
            3'b100:  op = OpXor;
            3'b010:  op = OpSlt;
            3'b011:  op = OpSltu;
`ifdef ALU_OP_CTRL_SHIFT_EN
            3'b001:  op = OpSll;
            3'b101:  op = f75 ? OpSra : OpSrl;
`endif
            default: op = OpIll;
        endcase
        return op;
    endfunction

    assign accept = start_i && (state_q == StIdle);

    always_comb begin
        dec_op = OpIll;
        dec_b  = imm_i;
        case (opcode_i)
            OPC_OP: begin
                dec_b  = rs2_val_i;
                dec_op = decode_f3(funct3_i, funct7_5_i, 1'b1);
            end
            OPC_OP_IMM:          dec_op = decode_f3(funct3_i, funct7_5_i, 1'b0);
            OPC_LOAD, OPC_STORE: dec_op = OpAdd;
            OPC_BRANCH: begin
                dec_b  = rs2_val_i;
                dec_op = OpSub;
            end
            default: ;
        endcase
    end

`ifdef ALU_OP_CTRL_SHIFT_EN
    logic         sh_load;
    logic         sh_busy;
    logic         sh_done;
    logic [N-1:0] sh_data;

    assign sh_load = accept && (dec_op inside {OpSll, OpSrl, OpSra});

    serial_shifter #(
        .Width (N)
    ) u_shifter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (sh_load),
        .data_i  (rs1_val_i),
        .shamt_i (dec_b[$clog2(N)-1:0]),
        .dir_i   (dec_op != OpSll),
        .arith_i (dec_op == OpSra),
        .data_o  (sh_data),
        .busy_o  (sh_busy),
        .done_o  (sh_done)
    );
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        tmp_d     = tmp_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = dec_op;
                    alu_a_d   = rs1_val_i;
                    alu_b_d   = dec_b;
                    alu_sel_d = first_sel(dec_op);
                    if (dec_op == OpIll) begin
                        result_d  = '0;
                        zero_d    = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = StDone;
                    end
`ifdef ALU_OP_CTRL_SHIFT_EN
                    else if (dec_op inside {OpSll, OpSrl, OpSra}) begin
                        state_d = StShift;
                    end
`endif
                    else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                if (op_q == OpXor) begin
                    // XOR = (a|b) & ~(a&b): keep the OR pass, run AND next.
                    tmp_d     = alu_result_i;
                    alu_sel_d = SEL_AND;
                    state_d   = StExec2;
                end else begin
                    result_d  = alu_result_i;
                    zero_d    = alu_zero_i;
                    illegal_d = 1'b0;
                    // On differing signs the subtraction may overflow, so the
                    // answer comes from the operand signs alone.
                    if (op_q == OpSlt) begin
                        result_d = {{(N-1){1'b0}}, (alu_a_q[N-1] != alu_b_q[N-1]) ?
                                    alu_a_q[N-1] : alu_result_i[N-1]};
                        zero_d   = ~result_d[0];
                    end else if (op_q == OpSltu) begin
                        result_d = {{(N-1){1'b0}}, (alu_a_q[N-1] != alu_b_q[N-1]) ?
                                    alu_b_q[N-1] : alu_result_i[N-1]};
                        zero_d   = ~result_d[0];
                    end
                    state_d = StDone;
                end
            end
            StExec2: begin
                result_d  = tmp_q & ~alu_result_i;
                zero_d    = (result_d == '0);
                illegal_d = 1'b0;
                state_d   = StDone;
            end
`ifdef ALU_OP_CTRL_SHIFT_EN
            StShift: begin
                if (sh_done || !sh_busy) begin
                    result_d  = sh_data;
                    zero_d    = (sh_data == '0);
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            op_q      <= OpAdd;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= SEL_ADD;
            tmp_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            tmp_q     <= tmp_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign ready_o     = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_sel_o   = alu_sel_q;
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Bench for alu_op_ctrl: attaches a behavioural ALU, issues instructions,
// pushes reference outcomes on a scoreboard queue and compares on out_valid.
module tb_alu_op_ctrl;

    localparam logic [6:0] OpcR  = 7'b0110011;
    localparam logic [6:0] OpcI  = 7'b0010011;
    localparam logic [6:0] OpcLd = 7'b0000011;
    localparam logic [6:0] OpcSt = 7'b0100011;
    localparam logic [6:0] OpcBr = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;
    logic        alu_zero;
    logic [31:0] result;
    logic        zero, illegal, out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_op_ctrl #(.N(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .ready_o      (ready),
        .opcode_i     (opcode),
        .funct3_i     (funct3),
        .funct7_5_i   (funct7_5),
        .rs1_val_i    (rs1_val),
        .rs2_val_i    (rs2_val),
        .imm_i        (imm),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_sel_o    (alu_sel),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .result_o     (result),
        .zero_o       (zero),
        .illegal_o    (illegal),
        .out_valid_o  (out_valid)
    );

    // femtoRV32 ALU model
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    typedef struct {
        string       name;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f75;
        logic [31:0] r1, r2, im;
        bit          poke;
    } stim_t;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
        logic [3:0]  sel1;
        bit          chk_ab;
        logic [31:0] a, b;
    } exp_t;

    exp_t  sb_q[$];
    stim_t tbl[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic stim_t mk(input string name, input logic [6:0] opc, input logic [2:0] f3,
                                 input logic f75, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] im, input bit poke);
        stim_t s;
        s.name = name; s.opc = opc; s.f3 = f3; s.f75 = f75;
        s.r1 = r1; s.r2 = r2; s.im = im; s.poke = poke;
        return s;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t        e;
        logic [31:0] a, b;
        logic [2:0]  f3;
        logic        sub;
        e.ill = 1'b0; e.lat = 2; e.sel1 = 4'b0010; e.chk_ab = 1'b1; e.res = '0;
        a = s.r1; b = s.r2; f3 = s.f3; sub = 1'b0;
        case (s.opc)
            OpcR:         begin b = s.r2; sub = s.f75; end
            OpcI:         begin b = s.im; end
            OpcLd, OpcSt: begin b = s.im; f3 = 3'b000; end
            OpcBr:        begin b = s.r2; f3 = 3'b000; sub = 1'b1; end
            default:      e.ill = 1'b1;
        endcase
        if (!e.ill) begin
            case (f3)
                3'b000: if (sub) begin e.res = a - b; e.sel1 = 4'b0110; end
                        else e.res = a + b;
                3'b111: begin e.res = a & b; e.sel1 = 4'b0000; end
                3'b110: begin e.res = a | b; e.sel1 = 4'b0001; end
                3'b100: begin e.res = a ^ b; e.sel1 = 4'b0001; e.lat = 3; end
                3'b010: begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.sel1 = 4'b0110; end
                3'b011: begin e.res = (a < b) ? 32'd1 : 32'd0; e.sel1 = 4'b0110; end
`ifdef ALU_OP_CTRL_SHIFT_EN
                3'b001: begin e.res = a << b[4:0]; e.lat = int'(b[4:0]) + 2; e.chk_ab = 1'b0; end
                3'b101: begin
                    e.res = s.f75 ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
                    e.lat = int'(b[4:0]) + 2; e.chk_ab = 1'b0;
                end
`endif
                default: e.ill = 1'b1;
            endcase
        end
        e.zero = (e.res == 32'd0);
        if (e.ill) begin
            e.res = '0; e.zero = 1'b1; e.lat = 1; e.chk_ab = 1'b0;
        end
        e.a = a; e.b = b;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        opcode = s.opc; funct3 = s.f3; funct7_5 = s.f75;
        rs1_val = s.r1; rs2_val = s.r2; imm = s.im;
        start = 1'b1;
    endtask

    task automatic run(input stim_t s);
        exp_t e, w;
        int   cyc, wait_n, extra;
        bit   seen;
        e = model(s);
        wait_n = 0;
        while (!ready && wait_n < 100) begin @(negedge clk); wait_n++; end
        check({s.name, ".ready"}, 32'(ready), 32'd1);
        drive(s);
        sb_q.push_back(e);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (s.poke) begin
                    // request while busy, must be dropped
                    opcode = OpcR; funct3 = 3'b000; funct7_5 = 1'b0;
                    rs1_val = 32'h1111_1111; rs2_val = 32'h2222_2222;
                end else begin
                    start = 1'b0;
                end
                if (!e.ill) check({s.name, ".sel1"}, 32'(alu_sel), 32'(e.sel1));
                if (e.chk_ab) begin
                    check({s.name, ".alu_a"}, alu_a, e.a);
                    check({s.name, ".alu_b"}, alu_b, e.b);
                end
            end
            if (cyc == 2) begin
                start = 1'b0;
                if (e.lat == 3) check({s.name, ".sel2"}, 32'(alu_sel), 32'b0000);
            end
            if (out_valid) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    check({s.name, ".unexpected_valid"}, 32'd1, 32'd0);
                end else begin
                    w = sb_q.pop_front();
                    check({s.name, ".result"},  result, w.res);
                    check({s.name, ".zero"},    32'(zero), 32'(w.zero));
                    check({s.name, ".illegal"}, 32'(illegal), 32'(w.ill));
                    check({s.name, ".latency"}, 32'(cyc), 32'(w.lat));
                end
            end
        end
        start = 1'b0;
        if (!seen) check({s.name, ".timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        check({s.name, ".pulse_width"}, 32'(out_valid), 32'd0);
        check({s.name, ".ready_after"}, 32'(ready), 32'd1);
        if (s.poke) begin
            extra = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (out_valid) extra++;
            end
            check({s.name, ".busy_start_ignored"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        int    abort_cyc, nval;
        logic [2:0] f3s [6];
        f3s = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010, 3'b011};

        rst = 1'b1; start = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        rs1_val = '0; rs2_val = '0; imm = '0;
        #3;
        check("reset.ready",     32'(ready),     32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result",    result,         32'd0);
        check("reset.zero",      32'(zero),      32'd0);
        check("reset.illegal",   32'(illegal),   32'd0);
        check("reset.alu_a",     alu_a,          32'd0);
        check("reset.alu_b",     alu_b,          32'd0);
        check("reset.alu_sel",   32'(alu_sel),   32'b0010);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        tbl.push_back(mk("add",     OpcR,  3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 1'b0));
        tbl.push_back(mk("beq_sub", OpcBr, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 1'b0));
        tbl.push_back(mk("xor",     OpcR,  3'b100, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b1));
        tbl.push_back(mk("slt",     OpcR,  3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0));
        tbl.push_back(mk("sltu",    OpcR,  3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0));
        tbl.push_back(mk("srai31",  OpcI,  3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_041F, 1'b0));
        tbl.push_back(mk("sll0",    OpcR,  3'b001, 1'b0, 32'h1234_5678, 32'd0, 32'd0, 1'b0));
        tbl.push_back(mk("sll3",    OpcR,  3'b001, 1'b0, 32'h8000_0001, 32'd3, 32'd0, 1'b0));
        tbl.push_back(mk("srl4",    OpcR,  3'b101, 1'b0, 32'h8000_00F0, 32'd4, 32'd0, 1'b0));
        tbl.push_back(mk("bad_opc", 7'b1111111, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 1'b0));
        tbl.push_back(mk("sub_neg", OpcR,  3'b000, 1'b1, 32'd3, 32'd10, 32'd0, 1'b0));
        tbl.push_back(mk("and",     OpcR,  3'b111, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0));
        tbl.push_back(mk("or",      OpcR,  3'b110, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'd0, 1'b0));
        tbl.push_back(mk("addi_f7", OpcI,  3'b000, 1'b1, 32'd100, 32'd0, 32'hFFFF_FC00, 1'b0));
        tbl.push_back(mk("load",    OpcLd, 3'b010, 1'b0, 32'h1000_0000, 32'd0, 32'h0000_0010, 1'b0));
        tbl.push_back(mk("store",   OpcSt, 3'b010, 1'b0, 32'h0000_0004, 32'd0, 32'hFFFF_FFFC, 1'b0));
        tbl.push_back(mk("slti",    OpcI,  3'b010, 1'b0, 32'h7FFF_FFFF, 32'd0, 32'h8000_0000, 1'b0));
        tbl.push_back(mk("xori_eq", OpcI,  3'b100, 1'b0, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, 1'b0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk($sformatf("rnd%0d", i), ($urandom_range(1, 0) == 0) ? OpcR : OpcI,
                             f3s[$urandom_range(5, 0)], 1'($urandom_range(1, 0)),
                             $urandom, $urandom, $urandom, 1'b0));
        end

        foreach (tbl[i]) run(tbl[i]);

        // Abort an in-flight request with reset.
        run(mk("pre_abort", OpcR, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 1'b0));
`ifdef ALU_OP_CTRL_SHIFT_EN
        s = mk("abort", OpcR, 3'b001, 1'b0, 32'h0000_0001, 32'd20, 32'd0, 1'b0);
        abort_cyc = 10;
`else
        s = mk("abort", OpcR, 3'b100, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 32'd0, 1'b0);
        abort_cyc = 1;
`endif
        drive(s);
        nval = 0;
        for (int c = 1; c <= abort_cyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) nval++;
        end
        check("abort.busy_before_rst", 32'(ready), 32'd0);
        rst = 1'b1;
        #1;
        check("abort.ready",     32'(ready),     32'd1);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.result",    result,         32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) nval++;
        end
        check("abort.no_valid",   32'(nval),  32'd0);
        check("abort.idle_after", 32'(ready), 32'd1);

        run(mk("post_abort", OpcR, 3'b000, 1'b0, 32'd40, 32'd2, 32'd0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_ctrl.md
# alu_op_ctrl

Sequencing front end for the combinational 32-bit ALU in the femtoRV32 datapath. It accepts one decoded instruction's operation fields and operand values through a start/ready handshake. It drives the ALU's `A`/`B`/`sel` inputs, running two passes where the ALU has no native op. It adds the missing RISC-V RV32I ALU operations (XOR, SLT, SLTU, iterative shifts) and returns a registered result, zero flag and one-cycle `out_valid` pulse to the execute stage.

## Interface
- `N`, 32, datapath width (only 32 supported)
- `clk` in 1, rising-edge clock
- `rst` in 1, asynchronous active-high reset
- `start` in 1, request; accepted only when `ready`=1
- `ready` out 1, high in IDLE only
- `opcode` in 7, instruction opcode
- `funct3` in 3, instruction funct3
- `funct7_5` in 1, instruction bit 30
- `rs1_val`, `rs2_val`, `imm` in 32, operand values (sampled on accept)
- `alu_a`, `alu_b` out 32, to ALU `A`/`B`
- `alu_sel` out 4, to ALU `sel` (0000 AND, 0001 OR, 0010 ADD, 0110 SUB)
- `alu_result` in 32, from ALU
- `alu_zero` in 1, from ALU zero flag
- `result` out 32, registered final result
- `zero` out 1, registered zero flag
- `illegal` out 1, registered; unsupported encoding
- `out_valid` out 1, one-cycle pulse, result/zero/illegal valid

## Operation
- Decode on accept:
  - opcode 0110011 (R-type): B=rs2.
  - opcode 0010011 (I-type): B=imm.
  - 0000011/0100011 (load/store): ADD rs1+imm.
  - 1100011 (branch): SUB rs1-rs2.
  - Any other opcode: illegal.
- funct3 mapping:
  - 000: ADD, or SUB if R-type and funct7_5=1.
  - 111: AND.
  - 110: OR.
  - 100: XOR.
  - 010: SLT.
  - 011: SLTU.
  - 001: SLL.
  - 101: SRL, or SRA if funct7_5=1.
- Operands `a`, `b` and the op are latched on accept. `alu_a`/`alu_b`/`alu_sel` come from registered state and are held stable for the whole pass.
- XOR: pass 1 OR latched to `tmp`; pass 2 AND; result = `tmp & ~alu_result`.
- SLT: SUB pass; result = {31'b0, (a[31]!=b[31]) ? a[31] : alu_result[31]}.
- SLTU: SUB pass; result = {31'b0, (a[31]!=b[31]) ? b[31] : alu_result[31]}.
- Shifts: shamt = b[4:0], one bit per cycle. SRA replicates a[31]. The ALU is not used; it is driven with sel=0010.
- zero:
  - = `alu_zero` for ADD/SUB/AND/OR.
  - = (result==0) for XOR/SLT/SLTU/shifts.
  - = 1 for illegal, with result=0.
- FSM states and transitions:
  - IDLE: start goes to EXEC, SHIFT or DONE (DONE when illegal).
  - EXEC: goes to EXEC2 if XOR, else DONE.
  - EXEC2: goes to DONE.
  - SHIFT: stays while count≠0, decrementing each cycle; goes to DONE when count=0.
  - DONE: `out_valid`=1, goes to IDLE.
- `start` while not ready is ignored, not queued.
- `result`/`zero`/`illegal` hold their value until the next DONE.

## Timing
- Accept in cycle 0 (start & ready).
- Latency to the `out_valid` cycle:
  - ADD/SUB/AND/OR/SLT/SLTU: cycle 2.
  - XOR: cycle 3.
  - Shift by k: cycle k+2 (k=0 gives cycle 2; k=31 gives cycle 33).
  - Illegal: cycle 1.
- `ready` rises the cycle after DONE, so the earliest back-to-back accept is latency+1.
- Reset values (async): state IDLE, `ready`=1, `out_valid`=0, `result`=0, `zero`=0, `illegal`=0, `alu_a`=0, `alu_b`=0, `alu_sel`=0010.
- Reset mid-operation aborts immediately. No `out_valid` is produced for the aborted request.
- All arithmetic is modulo 2^32. Carry-out is ignored.

## Configuration
- `ALU_OP_CTRL_SHIFT_EN` defined: SLL/SRL/SRA are implemented as above, including the SHIFT state and the serial shifter.
- `ALU_OP_CTRL_SHIFT_EN` undefined: funct3 001/101 decode as illegal and the SHIFT state and shifter are absent. All other behaviour is unchanged.

## Structure
- Package `alu_op_pkg`:
  - ALU sel constants (SEL_AND, SEL_OR, SEL_ADD, SEL_SUB).
  - Opcode constants.
  - Internal op enum (ADD..SRA, ILL).
  - FSM state enum.
- Sub-module `serial_shifter`: load/shamt/dir/arith inputs, one bit per cycle, `busy`/`done` outputs. Instantiated only under `ALU_OP_CTRL_SHIFT_EN`.

## Test plan
- R-type ADD, rs1=5, rs2=7, with ALU model attached -> `out_valid` at cycle 2, result=12, zero=0. Then branch SUB 9,9 -> result=0, zero=1.
- R-type XOR, rs1=0xF0F0_F0F0, rs2=0xFF00_FF00 -> `alu_sel` 0001 then 0000, `out_valid` at cycle 3, result=0x0FF0_0FF0.
- SLT/SLTU with a=0xFFFF_FFFF, b=1 -> SLT result=1, SLTU result=0, both `out_valid` at cycle 2.
- SRAI with a=0x8000_0000, imm shamt=31 -> `out_valid` at cycle 33, result=0xFFFF_FFFF. SLL with shamt 0 -> `out_valid` at cycle 2, result=a.
- opcode 1111111, and SLL when the macro is undefined -> `out_valid` at cycle 1 (macro-undefined SLL included), illegal=1, result=0, zero=1.
- Assert `rst` during cycle 10 of SLL shamt=20 -> state IDLE, `ready`=1, no `out_valid`. A `start` pulsed while busy is ignored.
